// File: rtl/virtio_mmio_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : virtio_mmio_pkg                                              |
// | Description : Shared constants, register offsets, response codes and the   |
// |               bus-handshake state encoding for the virtio-MMIO register    |
// |               block and its AXI4-Lite front end.                           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

package virtio_mmio_pkg;

  // Register offsets (only addr[7:0] is decoded)
  localparam logic [7:0] OFS_MAGIC              = 8'h00;
  localparam logic [7:0] OFS_VERSION            = 8'h04;
  localparam logic [7:0] OFS_DEVICE_ID          = 8'h08;
  localparam logic [7:0] OFS_VENDOR_ID          = 8'h0c;
  localparam logic [7:0] OFS_HOST_FEATURES      = 8'h10;
  localparam logic [7:0] OFS_HOST_FEATURES_SEL  = 8'h14;
  localparam logic [7:0] OFS_GUEST_FEATURES     = 8'h20;
  localparam logic [7:0] OFS_GUEST_FEATURES_SEL = 8'h24;
  localparam logic [7:0] OFS_GUEST_PAGE_SIZE    = 8'h28;
  localparam logic [7:0] OFS_QUEUE_SEL          = 8'h30;
  localparam logic [7:0] OFS_QUEUE_NUM_MAX      = 8'h34;
  localparam logic [7:0] OFS_QUEUE_NUM          = 8'h38;
  localparam logic [7:0] OFS_QUEUE_ALIGN        = 8'h3c;
  localparam logic [7:0] OFS_QUEUE_PFN          = 8'h40;
  localparam logic [7:0] OFS_QUEUE_NOTIFY       = 8'h50;
  localparam logic [7:0] OFS_INTERRUPT_STATUS   = 8'h60;
  localparam logic [7:0] OFS_INTERRUPT_ACK      = 8'h64;
  localparam logic [7:0] OFS_STATUS             = 8'h70;

  // Identification constants ("virt" and "QEMU" in little-endian ASCII)
  localparam logic [31:0] MAGIC_VALUE  = 32'h7472_6976;
  localparam logic [31:0] VENDOR_ID    = 32'h554d_4551;
  localparam logic [31:0] MMIO_VERSION = 32'h0000_0001;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RRESP = 2'd1,
    BRESP = 2'd2
  } state_t;

  // Replace the byte lanes of old_val selected by strb with those of data
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/virtio_axil_frontend.sv
// +----------------------------------------------------------------------------+
// | Module      : virtio_axil_frontend                                         |
// | Description : AXI4-Lite slave handshake engine. Latches AW and W beats     |
// |               independently, issues single-cycle read/write requests to    |
// |               the register file and returns the registered responses.      |
// | Ports       : clk/rstn, AXI4-Lite AW/W/B/AR/R channels (8-bit addresses),  |
// |               o_rd_req/o_rd_addr + i_rd_data/i_rd_err,                     |
// |               o_wr_req/o_wr_addr/o_wr_data/o_wr_strb + i_wr_err            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module virtio_axil_frontend
  import virtio_mmio_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  i_awaddr,
  input  logic        i_awvalid,
  output logic        o_awready,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  input  logic        i_wvalid,
  output logic        o_wready,
  output logic [1:0]  o_bresp,
  output logic        o_bvalid,
  input  logic        i_bready,
  input  logic [7:0]  i_araddr,
  input  logic        i_arvalid,
  output logic        o_arready,
  output logic [31:0] o_rdata,
  output logic [1:0]  o_rresp,
  output logic        o_rvalid,
  input  logic        i_rready,
  output logic        o_rd_req,
  output logic [7:0]  o_rd_addr,
  input  logic [31:0] i_rd_data,
  input  logic        i_rd_err,
  output logic        o_wr_req,
  output logic [7:0]  o_wr_addr,
  output logic [31:0] o_wr_data,
  output logic [3:0]  o_wr_strb,
  input  logic        i_wr_err
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_aw_held;
  logic        r_w_held;
  logic [7:0]  r_awaddr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic [1:0]  r_bresp;

  logic w_ar_fire;
  logic w_aw_fire;
  logic w_w_fire;
  logic w_wr_go;
  logic w_b_done;

  assign w_ar_fire = (r_state == IDLE) && i_arvalid;
  assign w_aw_fire = i_awvalid && !r_aw_held;
  assign w_w_fire  = i_wvalid && !r_w_held;
  // A pending read takes the slot; the held write simply waits in its latches
  assign w_wr_go   = (r_state == IDLE) && r_aw_held && r_w_held && !i_arvalid;
  assign w_b_done  = (r_state == BRESP) && i_bready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (i_arvalid)                   w_state_nxt = RRESP;
        else if (r_aw_held && r_w_held)  w_state_nxt = BRESP;
      end
      RRESP:   if (i_rready) w_state_nxt = IDLE;
      BRESP:   if (i_bready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_state <= w_state_nxt;

      // Latches stay full through the B phase so ready only reopens afterwards
      if (w_aw_fire) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= i_awaddr;
      end else if (w_b_done) begin
        r_aw_held <= 1'b0;
      end

      if (w_w_fire) begin
        r_w_held <= 1'b1;
        r_wdata  <= i_wdata;
        r_wstrb  <= i_wstrb;
      end else if (w_b_done) begin
        r_w_held <= 1'b0;
      end

      if (w_ar_fire) begin
        r_rdata <= i_rd_err ? 32'h0 : i_rd_data;
        r_rresp <= i_rd_err ? RESP_SLVERR : RESP_OKAY;
      end

      if (w_wr_go) begin
        r_bresp <= i_wr_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign o_awready = !r_aw_held;
  assign o_wready  = !r_w_held;
  assign o_arready = (r_state == IDLE);
  assign o_rvalid  = (r_state == RRESP);
  assign o_bvalid  = (r_state == BRESP);
  assign o_rdata   = r_rdata;
  assign o_rresp   = r_rresp;
  assign o_bresp   = r_bresp;

  assign o_rd_req  = w_ar_fire;
  assign o_rd_addr = i_araddr;
  assign o_wr_req  = w_wr_go;
  assign o_wr_addr = r_awaddr;
  assign o_wr_data = r_wdata;
  assign o_wr_strb = r_wstrb;

endmodule

`default_nettype wire

// File: rtl/virtio_mmio_regs.sv
// +----------------------------------------------------------------------------+
// | Module      : virtio_mmio_regs                                             |
// | Description : Legacy (version 1) virtio-MMIO register block behind an      |
// |               AXI4-Lite slave. Holds device/queue registers, interrupt     |
// |               status, and produces notify / device-reset pulses.           |
// | Ports       : clk/rstn, AXI4-Lite slave (axi_*), irq_set[1:0] in, irq out, |
// |               notify_valid/notify_queue, device_reset, guest_page_size,    |
// |               queue_{pfn,num,align}_flat (queue i at [32i+31:32i])         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module virtio_mmio_regs
  import virtio_mmio_pkg::*;
#(
  parameter int          NUM_QUEUES    = 1,
  parameter int          QUEUE_NUM_MAX = 8,
  parameter int          DEVICE_ID     = 2,
  parameter logic [31:0] HOST_FEATURES = 32'h0
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [31:0]               axi_awaddr,
  input  logic                      axi_awvalid,
  output logic                      axi_awready,
  input  logic [2:0]                axi_awprot,
  input  logic [31:0]               axi_wdata,
  input  logic [3:0]                axi_wstrb,
  input  logic                      axi_wvalid,
  output logic                      axi_wready,
  output logic [1:0]                axi_bresp,
  output logic                      axi_bvalid,
  input  logic                      axi_bready,
  input  logic [31:0]               axi_araddr,
  input  logic                      axi_arvalid,
  output logic                      axi_arready,
  input  logic [2:0]                axi_arprot,
  output logic [31:0]               axi_rdata,
  output logic [1:0]                axi_rresp,
  output logic                      axi_rvalid,
  input  logic                      axi_rready,
  input  logic [1:0]                irq_set,
  output logic                      irq,
  output logic                      notify_valid,
  output logic [2:0]                notify_queue,
  output logic                      device_reset,
  output logic [31:0]               guest_page_size,
  output logic [32*NUM_QUEUES-1:0]  queue_pfn_flat,
  output logic [32*NUM_QUEUES-1:0]  queue_num_flat,
  output logic [32*NUM_QUEUES-1:0]  queue_align_flat
);

  // Protection bits and the upper address bits carry no meaning here
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, axi_awprot, axi_arprot,
                         axi_awaddr[31:8], axi_araddr[31:8]};

  logic        w_rd_req;
  logic [7:0]  w_rd_addr;
  logic [31:0] w_rd_data;
  logic        w_rd_err;
  logic        w_wr_req;
  logic [7:0]  w_wr_addr;
  logic [31:0] w_wr_data;
  logic [3:0]  w_wr_strb;
  logic        w_wr_err;

  virtio_axil_frontend u_frontend (
    .clk       (clk),
    .rstn      (rstn),
    .i_awaddr  (axi_awaddr[7:0]),
    .i_awvalid (axi_awvalid),
    .o_awready (axi_awready),
    .i_wdata   (axi_wdata),
    .i_wstrb   (axi_wstrb),
    .i_wvalid  (axi_wvalid),
    .o_wready  (axi_wready),
    .o_bresp   (axi_bresp),
    .o_bvalid  (axi_bvalid),
    .i_bready  (axi_bready),
    .i_araddr  (axi_araddr[7:0]),
    .i_arvalid (axi_arvalid),
    .o_arready (axi_arready),
    .o_rdata   (axi_rdata),
    .o_rresp   (axi_rresp),
    .o_rvalid  (axi_rvalid),
    .i_rready  (axi_rready),
    .o_rd_req  (w_rd_req),
    .o_rd_addr (w_rd_addr),
    .i_rd_data (w_rd_data),
    .i_rd_err  (w_rd_err),
    .o_wr_req  (w_wr_req),
    .o_wr_addr (w_wr_addr),
    .o_wr_data (w_wr_data),
    .o_wr_strb (w_wr_strb),
    .i_wr_err  (w_wr_err)
  );

  logic [31:0] r_host_features_sel;
  logic [31:0] r_guest_features;
  logic [31:0] r_guest_features_sel;
  logic [31:0] r_guest_page_size;
  logic [31:0] r_queue_sel;
  logic [1:0]  r_int_status;
  logic [31:0] r_status;
  logic        r_notify_valid;
  logic [2:0]  r_notify_queue;
  logic        r_device_reset;

  logic        w_sel_ok;
  logic        w_wr_ok;
  logic        w_any_strb;
  logic [31:0] w_wr_val;
  logic        w_q_wr;
  logic        w_dev_reset;
  logic        w_notify;
  logic [1:0]  w_ack;
  logic [31:0] w_status_new;

  assign w_sel_ok   = (r_queue_sel < 32'(NUM_QUEUES));
  assign w_wr_ok    = w_wr_req && !w_wr_err;
  assign w_any_strb = |w_wr_strb;
  // Write data with unstrobed lanes forced to zero (notify / ack operands)
  assign w_wr_val   = merge_bytes(32'h0, w_wr_data, w_wr_strb);

  assign w_status_new = merge_bytes(r_status, w_wr_data, w_wr_strb);
  assign w_dev_reset  = w_wr_ok && (w_wr_addr == OFS_STATUS) && w_any_strb &&
                        (w_status_new == 32'h0);
  assign w_q_wr       = w_wr_ok && w_sel_ok &&
                        ((w_wr_addr == OFS_QUEUE_NUM) ||
                         (w_wr_addr == OFS_QUEUE_ALIGN) ||
                         (w_wr_addr == OFS_QUEUE_PFN));
  assign w_notify     = w_wr_ok && (w_wr_addr == OFS_QUEUE_NOTIFY) && w_any_strb &&
                        (w_wr_val < 32'(NUM_QUEUES));
  assign w_ack        = (w_wr_ok && (w_wr_addr == OFS_INTERRUPT_ACK)) ? w_wr_val[1:0] : 2'b00;

  always_comb begin
    w_wr_err = 1'b1;
    case (w_wr_addr)
      OFS_HOST_FEATURES_SEL, OFS_GUEST_FEATURES, OFS_GUEST_FEATURES_SEL,
      OFS_GUEST_PAGE_SIZE, OFS_QUEUE_SEL, OFS_QUEUE_NUM, OFS_QUEUE_ALIGN,
      OFS_QUEUE_PFN, OFS_QUEUE_NOTIFY, OFS_INTERRUPT_ACK, OFS_STATUS:
        w_wr_err = 1'b0;
      default: w_wr_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_host_features_sel  <= '0;
      r_guest_features     <= '0;
      r_guest_features_sel <= '0;
      r_guest_page_size    <= '0;
      r_queue_sel          <= '0;
      r_int_status         <= '0;
      r_status             <= '0;
      r_notify_valid       <= 1'b0;
      r_notify_queue       <= '0;
      r_device_reset       <= 1'b0;
    end else begin
      r_notify_valid <= w_notify;
      r_device_reset <= w_dev_reset;
      if (w_notify) r_notify_queue <= w_wr_val[2:0];

      // A new set in the same cycle as its ack survives
      if (w_dev_reset) r_int_status <= irq_set;
      else             r_int_status <= (r_int_status & ~w_ack) | irq_set;

      if (w_dev_reset) begin
        // Page size is deliberately kept across a driver-initiated reset
        r_host_features_sel  <= '0;
        r_guest_features     <= '0;
        r_guest_features_sel <= '0;
        r_queue_sel          <= '0;
        r_status             <= '0;
      end else if (w_wr_ok) begin
        case (w_wr_addr)
          OFS_HOST_FEATURES_SEL:  r_host_features_sel  <= merge_bytes(r_host_features_sel, w_wr_data, w_wr_strb);
          OFS_GUEST_FEATURES:     r_guest_features     <= merge_bytes(r_guest_features, w_wr_data, w_wr_strb);
          OFS_GUEST_FEATURES_SEL: r_guest_features_sel <= merge_bytes(r_guest_features_sel, w_wr_data, w_wr_strb);
          OFS_GUEST_PAGE_SIZE:    r_guest_page_size    <= merge_bytes(r_guest_page_size, w_wr_data, w_wr_strb);
          OFS_QUEUE_SEL:          r_queue_sel          <= merge_bytes(r_queue_sel, w_wr_data, w_wr_strb);
          OFS_STATUS:             r_status             <= w_status_new;
          default: ;
        endcase
      end
    end
  end

  for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_queue
    logic [31:0] r_num;
    logic [31:0] r_align;
    logic [31:0] r_pfn;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_num   <= '0;
        r_align <= '0;
        r_pfn   <= '0;
      end else if (w_dev_reset) begin
        r_num   <= '0;
        r_align <= '0;
        r_pfn   <= '0;
      end else if (w_q_wr && (r_queue_sel == 32'(i))) begin
        case (w_wr_addr)
          OFS_QUEUE_NUM:   r_num   <= merge_bytes(r_num, w_wr_data, w_wr_strb);
          OFS_QUEUE_ALIGN: r_align <= merge_bytes(r_align, w_wr_data, w_wr_strb);
          OFS_QUEUE_PFN:   r_pfn   <= merge_bytes(r_pfn, w_wr_data, w_wr_strb);
          default: ;
        endcase
      end
    end

    assign queue_num_flat[32*i +: 32]   = r_num;
    assign queue_align_flat[32*i +: 32] = r_align;
    assign queue_pfn_flat[32*i +: 32]   = r_pfn;
  end

  // Selected-queue view; stays zero when queue_sel is out of range
  logic [31:0] w_sel_num;
  logic [31:0] w_sel_align;
  logic [31:0] w_sel_pfn;

  always_comb begin
    w_sel_num   = '0;
    w_sel_align = '0;
    w_sel_pfn   = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (r_queue_sel == 32'(i)) begin
        w_sel_num   = queue_num_flat[32*i +: 32];
        w_sel_align = queue_align_flat[32*i +: 32];
        w_sel_pfn   = queue_pfn_flat[32*i +: 32];
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_err  = 1'b0;
    case (w_rd_addr)
      OFS_MAGIC:              w_rd_data = MAGIC_VALUE;
      OFS_VERSION:            w_rd_data = MMIO_VERSION;
      OFS_DEVICE_ID:          w_rd_data = 32'(DEVICE_ID);
      OFS_VENDOR_ID:          w_rd_data = VENDOR_ID;
      OFS_HOST_FEATURES:      w_rd_data = (r_host_features_sel == 32'h0) ? HOST_FEATURES : 32'h0;
      OFS_HOST_FEATURES_SEL:  w_rd_data = r_host_features_sel;
      OFS_GUEST_FEATURES:     w_rd_data = r_guest_features;
      OFS_GUEST_FEATURES_SEL: w_rd_data = r_guest_features_sel;
      OFS_GUEST_PAGE_SIZE:    w_rd_data = r_guest_page_size;
      OFS_QUEUE_SEL:          w_rd_data = r_queue_sel;
      OFS_QUEUE_NUM_MAX:      w_rd_data = w_sel_ok ? 32'(QUEUE_NUM_MAX) : 32'h0;
      OFS_QUEUE_NUM:          w_rd_data = w_sel_num;
      OFS_QUEUE_ALIGN:        w_rd_data = w_sel_align;
      OFS_QUEUE_PFN:          w_rd_data = w_sel_pfn;
      OFS_INTERRUPT_STATUS:   w_rd_data = {30'h0, r_int_status};
      OFS_STATUS:             w_rd_data = r_status;
      default:                w_rd_err  = 1'b1;
    endcase
  end

  assign irq             = |r_int_status;
  assign notify_valid    = r_notify_valid;
  assign notify_queue    = r_notify_queue;
  assign device_reset    = r_device_reset;
  assign guest_page_size = r_guest_page_size;

endmodule

`default_nettype wire

// File: tb/tb_virtio_mmio_regs.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_virtio_mmio_regs                                          |
// | Description : Directed self-checking bench for virtio_mmio_regs with two   |
// |               queues and a non-zero host feature word.                     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_virtio_mmio_regs;

  localparam int          NQ    = 2;
  localparam logic [31:0] HFEAT = 32'h0000_0201;

  logic            clk;
  logic            rstn;
  logic [31:0]     axi_awaddr;
  logic            axi_awvalid;
  logic            axi_awready;
  logic [2:0]      axi_awprot;
  logic [31:0]     axi_wdata;
  logic [3:0]      axi_wstrb;
  logic            axi_wvalid;
  logic            axi_wready;
  logic [1:0]      axi_bresp;
  logic            axi_bvalid;
  logic            axi_bready;
  logic [31:0]     axi_araddr;
  logic            axi_arvalid;
  logic            axi_arready;
  logic [2:0]      axi_arprot;
  logic [31:0]     axi_rdata;
  logic [1:0]      axi_rresp;
  logic            axi_rvalid;
  logic            axi_rready;
  logic [1:0]      irq_set;
  logic            irq;
  logic            notify_valid;
  logic [2:0]      notify_queue;
  logic            device_reset;
  logic [31:0]     guest_page_size;
  logic [32*NQ-1:0] queue_pfn_flat;
  logic [32*NQ-1:0] queue_num_flat;
  logic [32*NQ-1:0] queue_align_flat;

  virtio_mmio_regs #(
    .NUM_QUEUES    (NQ),
    .QUEUE_NUM_MAX (8),
    .DEVICE_ID     (2),
    .HOST_FEATURES (HFEAT)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .axi_awaddr       (axi_awaddr),
    .axi_awvalid      (axi_awvalid),
    .axi_awready      (axi_awready),
    .axi_awprot       (axi_awprot),
    .axi_wdata        (axi_wdata),
    .axi_wstrb        (axi_wstrb),
    .axi_wvalid       (axi_wvalid),
    .axi_wready       (axi_wready),
    .axi_bresp        (axi_bresp),
    .axi_bvalid       (axi_bvalid),
    .axi_bready       (axi_bready),
    .axi_araddr       (axi_araddr),
    .axi_arvalid      (axi_arvalid),
    .axi_arready      (axi_arready),
    .axi_arprot       (axi_arprot),
    .axi_rdata        (axi_rdata),
    .axi_rresp        (axi_rresp),
    .axi_rvalid       (axi_rvalid),
    .axi_rready       (axi_rready),
    .irq_set          (irq_set),
    .irq              (irq),
    .notify_valid     (notify_valid),
    .notify_queue     (notify_queue),
    .device_reset     (device_reset),
    .guest_page_size  (guest_page_size),
    .queue_pfn_flat   (queue_pfn_flat),
    .queue_num_flat   (queue_num_flat),
    .queue_align_flat (queue_align_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse counters; sampled on the edge, so each counts high cycles
  int         notify_cnt = 0;
  int         devrst_cnt = 0;
  logic [2:0] last_q     = 3'd0;
  always @(posedge clk) begin
    if (notify_valid) begin
      notify_cnt <= notify_cnt + 1;
      last_q     <= notify_queue;
    end
    if (device_reset) devrst_cnt <= devrst_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns data, response, and the number of cycles rvalid lagged the AR accept
  task automatic axi_read(input logic [7:0] a, output logic [31:0] d,
                          output logic [1:0] r, output int lat);
    int n;
    axi_araddr  = {24'h123456, a};
    axi_arvalid = 1'b1;
    n = 0;
    while (!axi_arready && n < 20) begin tick(); n++; end
    if (!axi_arready) check("ar_timeout", 64'd0, 64'd1);
    tick();
    axi_arvalid = 1'b0;
    n = 0;
    while (!axi_rvalid && n < 20) begin tick(); n++; end
    if (!axi_rvalid) check("r_timeout", 64'd0, 64'd1);
    lat = n;
    d = axi_rdata;
    r = axi_rresp;
    axi_rready = 1'b1;
    tick();
    axi_rready = 1'b0;
  endtask

  task automatic send_beats(input bit do_aw, input bit do_w);
    int n;
    bit aw_acc, w_acc;
    axi_awvalid = do_aw;
    axi_wvalid  = do_w;
    n = 0;
    while ((axi_awvalid || axi_wvalid) && n < 20) begin
      aw_acc = axi_awvalid && axi_awready;
      w_acc  = axi_wvalid && axi_wready;
      tick();
      if (aw_acc) axi_awvalid = 1'b0;
      if (w_acc)  axi_wvalid  = 1'b0;
      n++;
    end
    if (axi_awvalid || axi_wvalid) begin
      check("aw_w_timeout", 64'd0, 64'd1);
      axi_awvalid = 1'b0;
      axi_wvalid  = 1'b0;
    end
  endtask

  // w_lead>0: W beat goes w_lead cycles ahead of AW. lat counts cycles from
  // the last beat being latched to bvalid.
  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int w_lead, output logic [1:0] resp, output int lat);
    int n;
    axi_awaddr = {24'hFEDCBA, a};
    axi_wdata  = d;
    axi_wstrb  = s;
    if (w_lead == 0) begin
      send_beats(1'b1, 1'b1);
    end else begin
      send_beats(1'b0, 1'b1);
      repeat (w_lead - 1) tick();
      send_beats(1'b1, 1'b0);
    end
    n = 0;
    while (!axi_bvalid && n < 20) begin tick(); n++; end
    if (!axi_bvalid) check("b_timeout", 64'd0, 64'd1);
    lat  = n;
    resp = axi_bresp;
    axi_bready = 1'b1;
    tick();
    axi_bready = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [1:0] r;
    int l;
    axi_write(a, d, 4'hF, 0, r, l);
  endtask

  // Checks {resp,data} together: data must match and resp must be OKAY
  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    int l;
    axi_read(a, d, r, l);
    check(tag, {30'h0, r, d}, {30'h0, 2'b00, exp});
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    int          c0;

    rstn = 1'b0;
    axi_awaddr = '0; axi_awvalid = 1'b0; axi_awprot = 3'b000;
    axi_wdata = '0;  axi_wstrb = '0;     axi_wvalid = 1'b0; axi_bready = 1'b0;
    axi_araddr = '0; axi_arvalid = 1'b0; axi_arprot = 3'b000; axi_rready = 1'b0;
    irq_set = 2'b00;
    repeat (3) tick();

    // Reset values while still in reset, then after release
    check("rst_ctl_in_reset",
          {56'h0, axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid, irq, notify_valid, device_reset},
          {56'h0, 8'b1110_0000});
    rstn = 1'b1;
    tick();
    check("rst_ctl",
          {56'h0, axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid, irq, notify_valid, device_reset},
          {56'h0, 8'b1110_0000});
    check("rst_rdata_resp", {30'h0, axi_rresp, axi_rdata}, 64'h0);
    check("rst_gps", {32'h0, guest_page_size}, 64'h0);

    // Identification registers and read latency
    axi_read(8'h00, d, r, lat);
    check("magic", {30'h0, r, d}, {32'h0, 32'h7472_6976});
    check("rvalid_latency", 64'(lat), 64'd0);
    rd_chk("vendor", 8'h0c, 32'h554d_4551);
    rd_chk("device_id", 8'h08, 32'h2);
    rd_chk("version", 8'h04, 32'h1);

    // Feature word selection
    rd_chk("host_feat0", 8'h10, 32'h0000_0201);
    wr(8'h14, 32'h1);
    rd_chk("host_feat1", 8'h10, 32'h0);

    // Byte-lane merge onto zero
    axi_write(8'h28, 32'hAABB_CCDD, 4'b0101, 0, r, lat);
    check("gps_bresp", {62'h0, r}, 64'h0);
    rd_chk("gps_strb", 8'h28, 32'h00BB_00DD);
    check("gps_port", {32'h0, guest_page_size}, {32'h0, 32'h00BB_00DD});

    // Queue 1 PFN with W arriving two cycles before AW
    wr(8'h30, 32'h1);
    rd_chk("qnum_max_in", 8'h34, 32'd8);
    axi_write(8'h40, 32'h0001_2345, 4'hF, 2, r, lat);
    check("wfirst_bresp", {62'h0, r}, 64'h0);
    check("bvalid_latency", 64'(lat), 64'd1);
    rd_chk("q1_pfn", 8'h40, 32'h0001_2345);
    check("pfn_flat", queue_pfn_flat, {32'h0001_2345, 32'h0});
    wr(8'h38, 32'h10);
    check("num_flat", queue_num_flat, {32'h10, 32'h0});

    // Out-of-range queue_sel
    wr(8'h30, 32'h5);
    rd_chk("qnum_max_out", 8'h34, 32'h0);
    rd_chk("qpfn_out", 8'h40, 32'h0);
    axi_write(8'h40, 32'hDEAD_BEEF, 4'hF, 0, r, lat);
    check("qpfn_out_wr_bresp", {62'h0, r}, 64'h0);
    check("pfn_flat_unchanged", queue_pfn_flat, {32'h0001_2345, 32'h0});

    // QueueNotify in range and out of range
    c0 = notify_cnt;
    wr(8'h50, 32'h1);
    tick();
    check("notify_pulse_cnt", 64'(notify_cnt - c0), 64'd1);
    check("notify_queue", {61'h0, last_q}, 64'd1);
    c0 = notify_cnt;
    axi_write(8'h50, 32'h5, 4'hF, 0, r, lat);
    tick();
    check("notify_oor_bresp", {62'h0, r}, 64'h0);
    check("notify_oor_cnt", 64'(notify_cnt - c0), 64'd0);

    // Interrupt set, simultaneous set/ack, then plain ack
    irq_set = 2'b01;
    tick();
    irq_set = 2'b00;
    check("irq_set", {63'h0, irq}, 64'd1);
    rd_chk("int_status", 8'h60, 32'h1);
    irq_set = 2'b01;
    wr(8'h64, 32'h1);
    irq_set = 2'b00;
    tick();
    check("irq_set_wins", {63'h0, irq}, 64'd1);
    wr(8'h64, 32'h1);
    check("irq_acked", {63'h0, irq}, 64'd0);
    rd_chk("int_status_clr", 8'h60, 32'h0);

    // Error responses
    axi_read(8'h7c, d, r, lat);
    check("unmapped_rd", {30'h0, r, d}, {30'h0, 2'b10, 32'h0});
    axi_write(8'h00, 32'h1234_5678, 4'hF, 0, r, lat);
    check("ro_wr_bresp", {62'h0, r}, 64'd2);
    rd_chk("magic_after_ro_wr", 8'h00, 32'h7472_6976);

    // Status write of zero: device reset
    wr(8'h70, 32'h7);
    rd_chk("status", 8'h70, 32'h7);
    c0 = devrst_cnt;
    wr(8'h70, 32'h0);
    tick();
    check("devrst_cnt", 64'(devrst_cnt - c0), 64'd1);
    check("pfn_cleared", queue_pfn_flat, 64'h0);
    check("num_cleared", queue_num_flat, 64'h0);
    rd_chk("qsel_cleared", 8'h30, 32'h0);
    rd_chk("hfsel_cleared", 8'h14, 32'h0);
    rd_chk("gps_kept", 8'h28, 32'h00BB_00DD);

    // Reset while a write is latched but not yet committed
    axi_awaddr  = 32'h0000_0028;
    axi_wdata   = 32'h1111_1111;
    axi_wstrb   = 4'hF;
    axi_awvalid = 1'b1;
    axi_wvalid  = 1'b1;
    tick();
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    rstn = 1'b0;
    #1;
    check("midrst_bvalid", {63'h0, axi_bvalid}, 64'd0);
    check("midrst_ready", {62'h0, axi_awready, axi_wready}, 64'd3);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    check("midrst_bvalid_after", {63'h0, axi_bvalid}, 64'd0);
    check("midrst_gps", {32'h0, guest_page_size}, 64'h0);
    rd_chk("midrst_gps_rd", 8'h28, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Absolute time guard so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
